// File: rtl/bus_pkg.sv
// Shared types and constants for the bus responder: FSM state enum, data width, wait-counter width.
package bus_pkg;
    localparam int DATA_W     = 32;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } busState_e;
endpackage

// File: rtl/responder_ram.sv
// Single-port synchronous RAM: one-cycle read latency, read-before-write on a shared address.
module responder_ram
    import bus_pkg::*;
#(
    parameter int ADDR_BITS = 14
) (
    input  logic                 clk,
    input  logic                 writeEn,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_W-1:0]    writeData,
    output logic [DATA_W-1:0]    readData
);
    logic [DATA_W-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (writeEn) begin
            mem[addr] <= writeData;
        end
        readData <= mem[addr];
    end
endmodule

// File: rtl/bus_responder.sv
// Fixed-latency bus responder in front of an internal RAM (IDLE -> WAIT -> ACK).
// Optional memory-mapped debug register enabled by macro BUS_RESPONDER_DEBUG_REG_EN.
module bus_responder
    import bus_pkg::*;
#(
    parameter int ADDR_BITS   = 14,
    parameter int WAIT_STATES = 1
) (
    input  logic              CoreClock,
    input  logic              Reset,
    input  logic [31:0]       AddressBus,
    input  logic [31:0]       DataWriteBus,
    input  logic              WriteAssert,
    input  logic              ReadAssert,
    output logic [31:0]       DataReadBus,
    output logic              ReadOK,
    output logic              WriteOK,
    output logic [31:0]       DebugReg,
    output busState_e         FsmState
);
    // Handshake: a request is held by the initiator; it is sampled only in IDLE, and the
    // matching OK pulses for exactly one cycle in ACK, after which requests may be dropped.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

    busState_e               state, stateNext;
    logic [WAIT_CNT_W-1:0]   waitCnt, waitCntNext;
    logic                    accept, acceptWrite;
    logic [ADDR_BITS-1:0]    addrReg, ramAddr;
    logic [DATA_W-1:0]       dataReg, ramData, readHold, readSource;
    logic                    isWriteReg, ackRead, ackWrite, ramWe, targetDebug;
    logic                    unusedAddr;

    assign unusedAddr = ^AddressBus;

    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        accept      = 1'b0;
        acceptWrite = 1'b0;
        case (state)
            IDLE: begin
                if (WriteAssert || ReadAssert) begin
                    accept      = 1'b1;
                    acceptWrite = WriteAssert;
                    if (WAIT_STATES > 0) begin
                        stateNext   = WAIT;
                        waitCntNext = WAIT_LOAD;
                    end else begin
                        stateNext = ACK;
                    end
                end
            end
            WAIT: begin
                waitCntNext = waitCnt - 1'b1;
                if (waitCnt <= 1) begin
                    stateNext = ACK;
                end
            end
            ACK:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign ackRead  = (state == ACK) && !isWriteReg;
    assign ackWrite = (state == ACK) && isWriteReg;
    assign ReadOK   = ackRead;
    assign WriteOK  = ackWrite;
    assign FsmState = state;

    // Present the live address while idle so the RAM word is ready by ACK even with zero waits.
    assign ramAddr  = (state == IDLE) ? AddressBus[ADDR_BITS-1:0] : addrReg;
    assign ramWe    = ackWrite && !Reset && !targetDebug;

    always_ff @(posedge CoreClock) begin
        if (Reset) begin
            state      <= IDLE;
            waitCnt    <= '0;
            addrReg    <= '0;
            dataReg    <= '0;
            isWriteReg <= 1'b0;
            readHold   <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            if (accept) begin
                addrReg    <= AddressBus[ADDR_BITS-1:0];
                dataReg    <= DataWriteBus;
                isWriteReg <= acceptWrite;
            end
            if (ackRead) begin
                readHold <= readSource;
            end
        end
    end

`ifdef BUS_RESPONDER_DEBUG_REG_EN
    logic        isDebugReg;
    logic [31:0] debugValue;

    always_ff @(posedge CoreClock) begin
        if (Reset) begin
            isDebugReg <= 1'b0;
            debugValue <= '0;
        end else begin
            if (accept) begin
                isDebugReg <= AddressBus[ADDR_BITS];
            end
            if (ackWrite && isDebugReg) begin
                debugValue <= dataReg;
            end
        end
    end

    assign targetDebug = isDebugReg;
    assign readSource  = isDebugReg ? debugValue : ramData;
    assign DebugReg    = debugValue;
`else
    assign targetDebug = 1'b0;
    assign readSource  = ramData;
    assign DebugReg    = '0;
`endif

    assign DataReadBus = ackRead ? readSource : readHold;

    responder_ram #(
        .ADDR_BITS (ADDR_BITS)
    ) uRam (
        .clk       (CoreClock),
        .writeEn   (ramWe),
        .addr      (ramAddr),
        .writeData (dataReg),
        .readData  (ramData)
    );
endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder: three instances with WAIT_STATES of 1, 0 and 3.
module tb_bus_responder;
    import bus_pkg::*;

    localparam int N_INST = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         rst;
    logic [N_INST-1:0][31:0]      addrBus, wrData;
    logic [N_INST-1:0]            wrAssert, rdAssert;
    wire  [N_INST-1:0][31:0]      rdData, dbgReg;
    wire  [N_INST-1:0]            rdOk, wrOk;
    wire  [N_INST-1:0][1:0]       fsmState;

    int passCnt = 0;
    int totalCnt = 0;
    // Entry layout: {instance[1:0], isRead, readData (0 for writes)}
    logic [34:0] expQ[$];

    for (genvar g = 0; g < N_INST; g++) begin : gInst
        bus_responder #(
            .ADDR_BITS   (14),
            .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) dut (
            .CoreClock    (clk),
            .Reset        (rst),
            .AddressBus   (addrBus[g]),
            .DataWriteBus (wrData[g]),
            .WriteAssert  (wrAssert[g]),
            .ReadAssert   (rdAssert[g]),
            .DataReadBus  (rdData[g]),
            .ReadOK       (rdOk[g]),
            .WriteOK      (wrOk[g]),
            .DebugReg     (dbgReg[g]),
            .FsmState     (fsmState[g])
        );
    end

    function automatic int waitOf(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every OK pulse pops one expected entry.
    always @(negedge clk) begin
        logic [34:0] e, a;
        for (int g = 0; g < N_INST; g++) begin
            if (rdOk[g] || wrOk[g]) begin
                check("ok exclusive", 64'(rdOk[g] & wrOk[g]), 64'd0);
                if (expQ.size() == 0) begin
                    check("unexpected ok", 64'({rdOk[g], wrOk[g]}), 64'd0);
                end else begin
                    e = expQ.pop_front();
                    a = {2'(g), rdOk[g], rdOk[g] ? rdData[g] : 32'h0};
                    check("response", 64'(a), 64'(e));
                end
            end
        end
    end

    task automatic transact(input int g, input bit isWrite, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] expRd,
                            input string name, input bit dropEarly);
        int lat;
        bit seen;
        expQ.push_back({2'(g), !isWrite, isWrite ? 32'h0 : expRd});
        @(posedge clk); #1;
        addrBus[g]  = a;
        wrData[g]   = d;
        wrAssert[g] = isWrite;
        rdAssert[g] = !isWrite;
        @(posedge clk);
        if (dropEarly) begin
            #1;
            wrAssert[g] = 1'b0;
            rdAssert[g] = 1'b0;
        end
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (isWrite ? wrOk[g] : rdOk[g]) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        wrAssert[g] = 1'b0;
        rdAssert[g] = 1'b0;
        check({name, " latency"}, 64'(lat), 64'(1 + waitOf(g)));
    endtask

    task automatic bothReq();
        int latWr, latRd;
        expQ.push_back({2'd0, 1'b0, 32'h0});
        expQ.push_back({2'd0, 1'b1, 32'h12345678});
        @(posedge clk); #1;
        addrBus[0]  = 32'h0000_0003;
        wrData[0]   = 32'h1234_5678;
        wrAssert[0] = 1'b1;
        rdAssert[0] = 1'b1;
        @(posedge clk);
        latWr = 0;
        latRd = 0;
        for (int c = 1; c <= 60 && latRd == 0; c++) begin
            @(negedge clk);
            if (wrOk[0] && latWr == 0) begin
                latWr = c;
                wrAssert[0] = 1'b0;
            end
            if (rdOk[0]) latRd = c;
        end
        rdAssert[0] = 1'b0;
        check("both write latency", 64'(latWr), 64'd2);
        check("both read latency", 64'(latRd), 64'd5);
    endtask

    task automatic backToBackReads();
        int first, second;
        expQ.push_back({2'd1, 1'b1, 32'h11111111});
        expQ.push_back({2'd1, 1'b1, 32'h22222222});
        @(posedge clk); #1;
        addrBus[1]  = 32'h0000_0001;
        rdAssert[1] = 1'b1;
        @(posedge clk);
        first  = 0;
        second = 0;
        for (int c = 1; c <= 40 && second == 0; c++) begin
            @(negedge clk);
            if (rdOk[1]) begin
                if (first == 0) begin
                    first = c;
                    addrBus[1] = 32'h0000_0002;
                end else begin
                    second = c;
                end
            end
        end
        rdAssert[1] = 1'b0;
        check("b2b first latency", 64'(first), 64'd1);
        check("b2b second latency", 64'(second), 64'd3);
    endtask

    task automatic resetMidWrite();
        int okCount;
        @(posedge clk); #1;
        addrBus[2]  = 32'h0000_0020;
        wrData[2]   = 32'h5555_AAAA;
        wrAssert[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("in wait before reset", 64'(fsmState[2]), 64'(WAIT));
        wrAssert[2] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post reset state", 64'(fsmState[2]), 64'(IDLE));
        check("post reset readdata", 64'(rdData[2]), 64'd0);
        check("post reset debug", 64'(dbgReg[2]), 64'd0);
        okCount = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (wrOk != '0 || rdOk != '0) okCount++;
        end
        check("no ok after reset", 64'(okCount), 64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        addrBus  = '0;
        wrData   = '0;
        wrAssert = '0;
        rdAssert = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < N_INST; g++) begin
            check("reset rdOk", 64'(rdOk[g]), 64'd0);
            check("reset wrOk", 64'(wrOk[g]), 64'd0);
            check("reset rdData", 64'(rdData[g]), 64'd0);
            check("reset debug", 64'(dbgReg[g]), 64'd0);
            check("reset state", 64'(fsmState[g]), 64'(IDLE));
        end

        transact(0, 1'b1, 32'h0010, 32'hDEADBEEF, 32'h0, "wr 0x10", 1'b0);
        transact(0, 1'b0, 32'h0010, 32'h0, 32'hDEADBEEF, "rd 0x10", 1'b0);
        transact(0, 1'b1, 32'h0011, 32'h0000_1111, 32'h0, "wr 0x11", 1'b0);
        @(negedge clk);
        check("read data held", 64'(rdData[0]), 64'hDEADBEEF);
        transact(0, 1'b0, 32'h0011, 32'h0, 32'h0000_1111, "rd 0x11", 1'b0);

        bothReq();

        transact(1, 1'b1, 32'h0001, 32'h1111_1111, 32'h0, "wr 0x1", 1'b0);
        transact(1, 1'b1, 32'h0002, 32'h2222_2222, 32'h0, "wr 0x2", 1'b0);
        backToBackReads();

        transact(2, 1'b1, 32'h0020, 32'hA5A5_A5A5, 32'h0, "wr 0x20", 1'b0);
        resetMidWrite();
        transact(2, 1'b0, 32'h0020, 32'h0, 32'hA5A5_A5A5, "rd 0x20", 1'b0);
        transact(2, 1'b1, 32'h0021, 32'h0F0F_0F0F, 32'h0, "wr drop", 1'b1);
        transact(2, 1'b0, 32'h0021, 32'h0, 32'h0F0F_0F0F, "rd drop", 1'b1);

        transact(0, 1'b1, 32'h0000, 32'h0BAD_F00D, 32'h0, "wr 0x0", 1'b0);
        transact(0, 1'b1, 32'h4000, 32'h0000_03FF, 32'h0, "wr 0x4000", 1'b0);
        @(negedge clk);
`ifdef BUS_RESPONDER_DEBUG_REG_EN
        check("debug loaded", 64'(dbgReg[0]), 64'h3FF);
        transact(0, 1'b0, 32'h4000, 32'h0, 32'h0000_03FF, "rd debug", 1'b0);
        transact(0, 1'b0, 32'h0000, 32'h0, 32'h0BAD_F00D, "rd 0x0 kept", 1'b0);
        transact(0, 1'b1, 32'h0001_0005, 32'hCAFE_0005, 32'h0, "wr wrap", 1'b0);
`else
        check("debug constant", 64'(dbgReg[0]), 64'h0);
        transact(0, 1'b0, 32'h0000, 32'h0, 32'h0000_03FF, "rd 0x0 wrapped", 1'b0);
        transact(0, 1'b1, 32'h0001_4005, 32'hCAFE_0005, 32'h0, "wr wrap", 1'b0);
`endif
        transact(0, 1'b0, 32'h0005, 32'h0, 32'hCAFE_0005, "rd 0x5", 1'b0);

        repeat (5) @(negedge clk);
        check("queue drained", 64'(expQ.size()), 64'd0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
